cache_arbiter: RTL and testbench
================================

Name: cache_arbiter

Overview:
- Shares the single cache port (addr/wdata/rdata/read_enable/write_enable/miss) between the instruction-fetch and data-memory requesters of the core.
- Sits between the core pipeline and the cache, inside top, replacing direct pipeline drive of the cache signals.
- Sequences each access: grant, hold through misses, capture read data, acknowledge.
- Fixed priority data > fetch, with a streak limit so fetch is not starved.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_D_STREAK, 4, max consecutive data grants while fetch waits; range 1..15.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset.
- i_req  in  1  fetch request; held until i_ack.
- i_addr  in  ADDR_W  fetch address; stable while i_req.
- i_ack  out  1  one-cycle completion pulse to fetch.
- i_rdata  out  DATA_W  fetched word; valid while i_ack=1.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load; stable while d_req.
- d_addr  in  ADDR_W  data address; stable while d_req.
- d_wdata  in  DATA_W  store data; stable while d_req.
- d_ack  out  1  one-cycle completion pulse to data.
- d_rdata  out  DATA_W  load word; valid while d_ack=1.
- addr_cache  out  ADDR_W  cache address.
- wdata_cache  out  DATA_W  cache write data.
- rdata_cache  in  DATA_W  cache read data.
- write_enable_cache  out  1  cache write strobe.
- read_enable_cache  out  1  cache read strobe.
- miss_cache  in  1  1 = access not yet done; hold request.

Behaviour:
- Clock and reset: single clock clk; reset rstn is synchronous, active-low.
- Reset values:
  - State IDLE, streak = 0.
  - All cache outputs 0, both acks 0, both rdata outputs 0.
- States: IDLE, BUSY_I, BUSY_D, ACK_I, ACK_D. All cache outputs are registered.
- IDLE arbitration:
  - d_req && (!i_req || streak < MAX_D_STREAK) -> BUSY_D.
  - else i_req -> BUSY_I.
  - else stay in IDLE.
  - On entering BUSY_x, latch addr (and wdata/we for data) into the cache output registers. The enable goes high the cycle after the request is sampled.
- BUSY_D:
  - read_enable_cache = !d_we and write_enable_cache = d_we (latched values); exactly one is high.
  - Enables, addr and wdata are held constant while miss_cache = 1. There is no timeout.
  - On a cycle with miss_cache = 0: latch rdata_cache into d_rdata (loads only; stores leave d_rdata unchanged), drop both enables on the next edge, go to ACK_D.
- BUSY_I: as BUSY_D with read_enable_cache only, rdata captured into i_rdata, next state ACK_I.
- ACK_x:
  - ack_x = 1 for exactly this cycle; the next state is IDLE.
  - Cache enables are 0 in this cycle.
  - The requester may drop req_x or present a new request in the same cycle; the arbiter does not sample requests in ACK_x.
- Latency:
  - Hit (miss_cache = 0 on the first enabled cycle): request sampled at cycle t -> enable at t+1 -> ack at t+2.
  - Minimum spacing between back-to-back grants: 3 cycles.
  - Each miss cycle adds 1.
- Streak counter (4 bits):
  - Increments on each data grant made while i_req = 1.
  - Clears on any fetch grant, and on a data grant made while i_req = 0.
  - Saturates at MAX_D_STREAK.
- Simultaneous events:
  - Both requests in IDLE -> data wins unless streak == MAX_D_STREAK.
  - A request arriving while BUSY waits; it is never dropped.
- No preemption: a granted access runs to completion regardless of new requests.
- Reset mid-access:
  - The next edge forces IDLE and deasserts the enables; no ack is issued for the abandoned access.
  - Requesters are reset by the same rstn.
- Requester protocol violations (req dropped before ack) are unsupported. The assertion in the bench flags them.

Decomposition:
- Package cache_arb_pkg holds the state encoding localparams (IDLE = 0, BUSY_I, BUSY_D, ACK_I, ACK_D) and the shared ADDR_W/DATA_W defaults.
- No sub-module; the streak counter and the FSM sit in one always block pair (next-state plus registers).
- top instantiates the arbiter between the core and the existing cache ports.

Test Plan:
- Single fetch, hit: i_req = 1, i_addr = 0x100, rdata_cache = 0xDEADBEEF, miss_cache = 0 -> read_enable_cache high for 1 cycle with addr 0x100; i_ack at t+2; i_rdata = 0xDEADBEEF.
- Store with 3-cycle miss: d_req = 1, d_we = 1, d_addr = 0x2000, d_wdata = 0x12345678, miss_cache = 1 for 3 cycles -> write_enable/addr/wdata constant for 4 cycles; d_ack at t+5; read_enable_cache never high.
- Simultaneous requests: i_req and d_req both at t with streak 0 -> data served first (d_ack at t+2), then fetch granted at t+3 (i_ack at t+5).
- Starvation guard, MAX_D_STREAK = 4: d_req and i_req held continuously -> grant order D, D, D, D, I, D..., with the streak clearing after the fetch.
- Reset mid-miss: rstn = 0 during BUSY_D with miss_cache = 1 -> next cycle all cache enables 0, no d_ack, state IDLE; after release, a fresh d_req completes normally.
- Back-to-back loads: the requester re-asserts d_req in the ACK_D cycle -> the next read_enable_cache rises exactly 2 cycles after the previous ack; no glitch on the enables.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache port arbiter: state encoding, default
// bus widths and the streak counter width.
package cache_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned STREAK_W   = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BUSY_I = 3'd1,
    BUSY_D = 3'd2,
    ACK_I  = 3'd3,
    ACK_D  = 3'd4
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one cache port between instruction fetch and data access.
// Data has priority; a streak limit keeps a waiting fetch from starving.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] addr_cache,
  output logic [DATA_W-1:0] wdata_cache,
  input  logic [DATA_W-1:0] rdata_cache,
  output logic              write_enable_cache,
  output logic              read_enable_cache,
  input  logic              miss_cache
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  arb_state_t          state, state_n;
  logic [STREAK_W-1:0] streak, streak_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   wdata_n, i_rdata_n, d_rdata_n;
  logic                we_n, re_n, i_ack_n, d_ack_n;
  logic                d_grant_c;

  // Data wins unless a waiting fetch has already been passed over MAX_D_STREAK times.
  assign d_grant_c = d_req && (!i_req || (streak < STREAK_MAX));

  // Next-state and next-register values; everything holds unless changed below.
  always_comb begin
    state_n   = state;
    streak_n  = streak;
    addr_n    = addr_cache;
    wdata_n   = wdata_cache;
    we_n      = write_enable_cache;
    re_n      = read_enable_cache;
    i_rdata_n = i_rdata;
    d_rdata_n = d_rdata;
    i_ack_n   = 1'b0;
    d_ack_n   = 1'b0;
    case (state)
      IDLE: begin
        if (d_grant_c) begin
          state_n = BUSY_D;
          addr_n  = d_addr;
          wdata_n = d_wdata;
          we_n    = d_we;
          re_n    = !d_we;
          if (!i_req)
            streak_n = '0;
          else if (streak < STREAK_MAX)
            streak_n = streak + STREAK_W'(1);
        end else if (i_req) begin
          state_n  = BUSY_I;
          addr_n   = i_addr;
          we_n     = 1'b0;
          re_n     = 1'b1;
          streak_n = '0;
        end
      end
      BUSY_I: begin
        if (!miss_cache) begin
          state_n   = ACK_I;
          i_rdata_n = rdata_cache;
          re_n      = 1'b0;
          i_ack_n   = 1'b1;
        end
      end
      BUSY_D: begin
        if (!miss_cache) begin
          state_n = ACK_D;
          if (!write_enable_cache)
            d_rdata_n = rdata_cache;
          re_n    = 1'b0;
          we_n    = 1'b0;
          d_ack_n = 1'b1;
        end
      end
      ACK_I, ACK_D: state_n = IDLE;
      default: begin
        state_n = IDLE;
        re_n    = 1'b0;
        we_n    = 1'b0;
      end
    endcase
  end

  // State, streak and all outputs registered; reset abandons any access silently.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state              <= IDLE;
      streak             <= '0;
      addr_cache         <= '0;
      wdata_cache        <= '0;
      write_enable_cache <= 1'b0;
      read_enable_cache  <= 1'b0;
      i_rdata            <= '0;
      d_rdata            <= '0;
      i_ack              <= 1'b0;
      d_ack              <= 1'b0;
    end else begin
      state              <= state_n;
      streak             <= streak_n;
      addr_cache         <= addr_n;
      wdata_cache        <= wdata_n;
      write_enable_cache <= we_n;
      read_enable_cache  <= re_n;
      i_rdata            <= i_rdata_n;
      d_rdata            <= d_rdata_n;
      i_ack              <= i_ack_n;
      d_ack              <= d_ack_n;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: per-cycle vector table plus hand-written
// sequences for fetch starvation and reset during a miss.
module tb_cache_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, miss_cache = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, rdata_cache = '0;
  logic          i_ack, d_ack, write_enable_cache, read_enable_cache;
  logic [DW-1:0] i_rdata, d_rdata, wdata_cache;
  logic [AW-1:0] addr_cache;

  int checks = 0;
  int errors = 0;

  cache_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(4)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .addr_cache(addr_cache), .wdata_cache(wdata_cache), .rdata_cache(rdata_cache),
    .write_enable_cache(write_enable_cache), .read_enable_cache(read_enable_cache),
    .miss_cache(miss_cache)
  );

  always #5 clk = ~clk;

  // Requester protocol: a request may only drop in or after its ack cycle.
  logic pi_req = 1'b0, pi_ack = 1'b0, pd_req = 1'b0, pd_ack = 1'b0;
  always @(posedge clk) begin
    if (!rstn) begin
      pi_req <= 1'b0; pi_ack <= 1'b0; pd_req <= 1'b0; pd_ack <= 1'b0;
    end else begin
      assert (!(pi_req && !pi_ack && !i_req && !i_ack))
        else $error("protocol violation: i_req dropped before i_ack");
      assert (!(pd_req && !pd_ack && !d_req && !d_ack))
        else $error("protocol violation: d_req dropped before d_ack");
      pi_req <= i_req; pi_ack <= i_ack; pd_req <= d_req; pd_ack <= d_ack;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        ir;  logic [31:0] ia;
    logic        dr;  logic dw; logic [31:0] da; logic [31:0] dd;
    logic [31:0] rd;  logic ms;
    logic        ere; logic ewe; logic [31:0] ea; logic [31:0] ew;
    logic        eia; logic eda; logic [31:0] eir; logic [31:0] edr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic ir, input logic [31:0] ia,
                     input logic dr, input logic dw, input logic [31:0] da,
                     input logic [31:0] dd, input logic [31:0] rd, input logic ms,
                     input logic ere, input logic ewe, input logic [31:0] ea,
                     input logic [31:0] ew, input logic eia, input logic eda,
                     input logic [31:0] eir, input logic [31:0] edr);
    vec_t v;
    v.name = nm; v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.rd = rd; v.ms = ms; v.ere = ere; v.ewe = ewe; v.ea = ea; v.ew = ew;
    v.eia = eia; v.eda = eda; v.eir = eir; v.edr = edr;
    vecs.push_back(v);
  endtask

  logic [31:0] exp_g [10];

  initial begin
    // Inputs apply during one cycle; expectations are the registered outputs after its edge.
    //   name            ir ia     dr dw da       dd         rd         ms  re we ea       ew         ia da irdata     drdata
    add("fetch_req",     1, 'h100, 0, 0, 0,       0,         'hDEADBEEF, 0, 1, 0, 'h100,  0,         0, 0, 0,         0);
    add("fetch_hit",     1, 'h100, 0, 0, 0,       0,         'hDEADBEEF, 0, 0, 0, 0,      0,         1, 0, 'hDEADBEEF, 0);
    add("fetch_idle",    0, 0,     0, 0, 0,       0,         0,          0, 0, 0, 0,      0,         0, 0, 'hDEADBEEF, 0);
    add("st_req",        0, 0,     1, 1, 'h2000, 'h12345678, 'hAAAA5555, 1, 0, 1, 'h2000, 'h12345678, 0, 0, 'hDEADBEEF, 0);
    add("st_miss1",      0, 0,     1, 1, 'h2000, 'h12345678, 'hAAAA5555, 1, 0, 1, 'h2000, 'h12345678, 0, 0, 'hDEADBEEF, 0);
    add("st_miss2",      0, 0,     1, 1, 'h2000, 'h12345678, 'hAAAA5555, 1, 0, 1, 'h2000, 'h12345678, 0, 0, 'hDEADBEEF, 0);
    add("st_miss3",      0, 0,     1, 1, 'h2000, 'h12345678, 'hAAAA5555, 1, 0, 1, 'h2000, 'h12345678, 0, 0, 'hDEADBEEF, 0);
    add("st_done",       0, 0,     1, 1, 'h2000, 'h12345678, 'hAAAA5555, 0, 0, 0, 0,      0,         0, 1, 'hDEADBEEF, 0);
    add("st_idle",       0, 0,     0, 0, 0,       0,         0,          0, 0, 0, 0,      0,         0, 0, 'hDEADBEEF, 0);
    add("both_d_grant",  1, 'h104, 1, 0, 'h3000, 0,          'h11112222, 0, 1, 0, 'h3000, 0,         0, 0, 'hDEADBEEF, 0);
    add("both_d_done",   1, 'h104, 1, 0, 'h3000, 0,          'h11112222, 0, 0, 0, 0,      0,         0, 1, 'hDEADBEEF, 'h11112222);
    add("both_d_ackcyc", 1, 'h104, 0, 0, 0,       0,         'h33334444, 0, 0, 0, 0,      0,         0, 0, 'hDEADBEEF, 'h11112222);
    add("both_i_grant",  1, 'h104, 0, 0, 0,       0,         'h33334444, 0, 1, 0, 'h104,  0,         0, 0, 'hDEADBEEF, 'h11112222);
    add("both_i_done",   1, 'h104, 0, 0, 0,       0,         'h33334444, 0, 0, 0, 0,      0,         1, 0, 'h33334444, 'h11112222);
    add("both_idle",     0, 0,     0, 0, 0,       0,         0,          0, 0, 0, 0,      0,         0, 0, 'h33334444, 'h11112222);
    add("b2b_grant0",    0, 0,     1, 0, 'h40,   0,          'h0A0A0A0A, 0, 1, 0, 'h40,   0,         0, 0, 'h33334444, 'h11112222);
    add("b2b_done0",     0, 0,     1, 0, 'h40,   0,          'h0A0A0A0A, 0, 0, 0, 0,      0,         0, 1, 'h33334444, 'h0A0A0A0A);
    add("b2b_rereq",     0, 0,     1, 0, 'h44,   0,          'h0B0B0B0B, 0, 0, 0, 0,      0,         0, 0, 'h33334444, 'h0A0A0A0A);
    add("b2b_grant1",    0, 0,     1, 0, 'h44,   0,          'h0B0B0B0B, 0, 1, 0, 'h44,   0,         0, 0, 'h33334444, 'h0A0A0A0A);
    add("b2b_done1",     0, 0,     1, 0, 'h44,   0,          'h0B0B0B0B, 0, 0, 0, 0,      0,         0, 1, 'h33334444, 'h0B0B0B0B);
    add("st2_rereq",     0, 0,     1, 1, 'h48,   'hCAFEF00D, 'hFFFFFFFF, 0, 0, 0, 0,      0,         0, 0, 'h33334444, 'h0B0B0B0B);
    add("st2_grant",     0, 0,     1, 1, 'h48,   'hCAFEF00D, 'hFFFFFFFF, 0, 0, 1, 'h48,   'hCAFEF00D, 0, 0, 'h33334444, 'h0B0B0B0B);
    add("st2_done",      0, 0,     1, 1, 'h48,   'hCAFEF00D, 'hFFFFFFFF, 0, 0, 0, 0,      0,         0, 1, 'h33334444, 'h0B0B0B0B);
    add("st2_idle",      0, 0,     0, 0, 0,       0,         0,          0, 0, 0, 0,      0,         0, 0, 'h33334444, 'h0B0B0B0B);

    // Reset with a request pending: every output must sit at zero.
    d_req = 1'b1; d_addr = 'h55;
    repeat (2) @(posedge clk);
    @(negedge clk); d_req = 1'b0; d_addr = '0;
    @(posedge clk); #1;
    check("rst_re", 32'(read_enable_cache), 0);
    check("rst_we", 32'(write_enable_cache), 0);
    check("rst_addr", addr_cache, 0);
    check("rst_wdata", wdata_cache, 0);
    check("rst_i_ack", 32'(i_ack), 0);
    check("rst_d_ack", 32'(d_ack), 0);
    check("rst_i_rdata", i_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    @(negedge clk); rstn = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      i_req = vecs[k].ir; i_addr = vecs[k].ia; d_req = vecs[k].dr; d_we = vecs[k].dw;
      d_addr = vecs[k].da; d_wdata = vecs[k].dd; rdata_cache = vecs[k].rd;
      miss_cache = vecs[k].ms;
      @(posedge clk); #1;
      check({vecs[k].name, ".re"}, 32'(read_enable_cache), 32'(vecs[k].ere));
      check({vecs[k].name, ".we"}, 32'(write_enable_cache), 32'(vecs[k].ewe));
      check({vecs[k].name, ".i_ack"}, 32'(i_ack), 32'(vecs[k].eia));
      check({vecs[k].name, ".d_ack"}, 32'(d_ack), 32'(vecs[k].eda));
      check({vecs[k].name, ".i_rdata"}, i_rdata, vecs[k].eir);
      check({vecs[k].name, ".d_rdata"}, d_rdata, vecs[k].edr);
      if (vecs[k].ere || vecs[k].ewe) check({vecs[k].name, ".addr"}, addr_cache, vecs[k].ea);
      if (vecs[k].ewe) check({vecs[k].name, ".wdata"}, wdata_cache, vecs[k].ew);
    end

    // Starvation guard: both requesters always busy -> D,D,D,D,I repeating.
    exp_g[0] = 'h600; exp_g[1] = 'h600; exp_g[2] = 'h600; exp_g[3] = 'h600; exp_g[4] = 'h500;
    exp_g[5] = 'h600; exp_g[6] = 'h600; exp_g[7] = 'h600; exp_g[8] = 'h600; exp_g[9] = 'h500;
    begin
      int   g;
      logic prev_re;
      g = 0; prev_re = 1'b0;
      @(negedge clk);
      i_req = 1'b1; i_addr = 'h500; d_req = 1'b1; d_we = 1'b0; d_addr = 'h600;
      rdata_cache = 'h1234; miss_cache = 1'b0;
      for (int cyc = 0; cyc < 200 && (i_req || d_req); cyc++) begin
        @(posedge clk); #1;
        if (read_enable_cache && !prev_re) begin
          if (g < 10) check($sformatf("grant%0d_addr", g), addr_cache, exp_g[g]);
          g++;
        end
        prev_re = read_enable_cache;
        if (g >= 10) begin
          if (i_ack) i_req = 1'b0;
          if (d_ack) d_req = 1'b0;
        end
      end
      check("starve_grant_count_min", 32'(g >= 10), 1);
      check("starve_drained", 32'(i_req || d_req), 0);
      i_req = 1'b0; d_req = 1'b0;
    end

    // Reset while a store is stuck in a miss, then a fresh load.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 'h700; d_wdata = 'h5A5A5A5A; miss_cache = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk); #1;
      if (write_enable_cache) break;
    end
    check("rmm_we_up", 32'(write_enable_cache), 1);
    @(posedge clk); #1;
    @(negedge clk); rstn = 1'b0; d_req = 1'b0;
    @(posedge clk); #1;
    check("rmm_we", 32'(write_enable_cache), 0);
    check("rmm_re", 32'(read_enable_cache), 0);
    check("rmm_d_ack", 32'(d_ack), 0);
    @(posedge clk); #1;
    check("rmm_d_ack2", 32'(d_ack), 0);
    @(negedge clk);
    rstn = 1'b1; miss_cache = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 'h704;
    rdata_cache = 'h77;
    @(posedge clk); #1;
    check("rmm_new_re", 32'(read_enable_cache), 1);
    check("rmm_new_addr", addr_cache, 'h704);
    @(posedge clk); #1;
    check("rmm_new_ack", 32'(d_ack), 1);
    check("rmm_new_rdata", d_rdata, 'h77);
    @(negedge clk); d_req = 1'b0;
    @(posedge clk); #1;
    check("rmm_ack_pulse", 32'(d_ack), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
